icache_ctrl: RTL and testbench

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_icache_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ctrl
// Direct-mapped instruction cache controller. It performs the tag lookup
// against external valid/tag arrays, refills a missing line from memory one
// word per beat into an external data array, then commits the new tag.
//
// Optional build macro: ICACHE_FLUSH_EN
//   Adds the flush / flush_done ports and a FLUSH state that walks every
//   index clearing its valid bit. Without it, invalidation is left to the
//   reset of the meta arrays.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   flush, flush_done invalidate-all request / completion pulse (macro only)
//   cpu_req, cpu_addr fetch request and byte address
//   cpu_hit           lookup hits this cycle (IDLE only, combinational)
//   cpu_stall         cpu_req & ~cpu_hit
//   meta_*            valid/tag array index, read data, write port
//   data_*            data array write port (index, word offset, word)
//   mem_req, mem_addr memory read request and word-aligned address
//   mem_ack, mem_rdata one returned beat and its data
// -----------------------------------------------------------------------------
module icache_ctrl #(
    parameter int BLKIDX_BIT = 4,
    parameter int OFF_BIT    = 2,
    localparam int BLK_NUM   = 2 ** BLKIDX_BIT,
    localparam int WORDS     = 2 ** OFF_BIT,
    localparam int TAG_BIT   = 30 - OFF_BIT - BLKIDX_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ICACHE_FLUSH_EN
    input  logic                  flush,
    output logic                  flush_done,
`endif
    input  logic                  cpu_req,
    input  logic [31:0]           cpu_addr,
    output logic                  cpu_hit,
    output logic                  cpu_stall,
    output logic [BLKIDX_BIT-1:0] meta_idx,
    input  logic                  meta_valid_r,
    input  logic [TAG_BIT-1:0]    meta_tag_r,
    output logic                  meta_wen,
    output logic                  meta_valid_w,
    output logic [TAG_BIT-1:0]    meta_tag_w,
    output logic                  data_wen,
    output logic [BLKIDX_BIT-1:0] data_idx,
    output logic [OFF_BIT-1:0]    data_off,
    output logic [31:0]           data_wdata,
    output logic                  mem_req,
    output logic [31:0]           mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    localparam logic [OFF_BIT-1:0]    LAST_OFF = OFF_BIT'(WORDS - 1);
    localparam logic [BLKIDX_BIT-1:0] LAST_IDX = BLKIDX_BIT'(BLK_NUM - 1);

`ifdef ICACHE_FLUSH_EN
    typedef enum logic [1:0] {IDLE, REFILL, COMMIT, FLUSH} state_t;
`else
    typedef enum logic [1:0] {IDLE, REFILL, COMMIT} state_t;
`endif

    state_t                  state;
    logic [OFF_BIT-1:0]      cnt;
    logic [BLKIDX_BIT-1:0]   lat_idx;
    logic [TAG_BIT-1:0]      lat_tag;
    logic                    mem_req_r;

    // Address fields of the incoming fetch
    logic [OFF_BIT-1:0]      req_off;
    logic [BLKIDX_BIT-1:0]   req_idx;
    logic [TAG_BIT-1:0]      req_tag;
    logic                    tag_match;
    logic                    flush_go;
    logic                    unused_ok;

    assign req_off   = cpu_addr[2 +: OFF_BIT];
    assign req_idx   = cpu_addr[OFF_BIT + 2 +: BLKIDX_BIT];
    assign req_tag   = cpu_addr[31 -: TAG_BIT];
    assign tag_match = meta_valid_r & (meta_tag_r == req_tag);

`ifdef ICACHE_FLUSH_EN
    logic [BLKIDX_BIT-1:0]   fcnt;
    logic                    flush_pend;

    // A flush seen in IDLE (live or recorded during a refill) wins over the
    // fetch; the fetch simply stalls and is looked up again afterwards.
    assign flush_go  = (state == IDLE) & (flush | flush_pend);
    assign unused_ok = ^cpu_addr[1:0];
`else
    assign flush_go  = 1'b0;
    assign unused_ok = ^{cpu_addr[1:0], LAST_IDX};
`endif

    // -------------------------------------------------------------------------
    // State machine and registered request
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_idx    <= '0;
            lat_tag    <= '0;
            mem_req_r  <= 1'b0;
`ifdef ICACHE_FLUSH_EN
            fcnt       <= '0;
            flush_pend <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (flush_go) begin
`ifdef ICACHE_FLUSH_EN
                        state      <= FLUSH;
                        fcnt       <= '0;
                        flush_pend <= 1'b0;
`endif
                    end else if (cpu_req && !tag_match) begin
                        state     <= REFILL;
                        lat_idx   <= req_idx;
                        lat_tag   <= req_tag;
                        cnt       <= '0;
                        mem_req_r <= 1'b1;
                    end
                end

                REFILL: begin
`ifdef ICACHE_FLUSH_EN
                    if (flush) flush_pend <= 1'b1;
`endif
                    if (mem_ack) begin
                        // Compared before increment, so the counter wraps
                        // to zero exactly as the last beat is accepted.
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_OFF) begin
                            state     <= COMMIT;
                            mem_req_r <= 1'b0;
                        end
                    end
                end

                COMMIT: begin
`ifdef ICACHE_FLUSH_EN
                    if (flush) flush_pend <= 1'b1;
`endif
                    state <= IDLE;
                end

`ifdef ICACHE_FLUSH_EN
                FLUSH: begin
                    fcnt <= fcnt + 1'b1;
                    if (fcnt == LAST_IDX) state <= IDLE;
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Array ports and CPU handshake
    // -------------------------------------------------------------------------
    // Writes are masked while rst is high so a refill cut short by reset
    // never commits a tag or writes a stray beat.
    always_comb begin
        meta_idx     = lat_idx;
        data_idx     = lat_idx;
        data_off     = cnt;
        meta_wen     = 1'b0;
        meta_valid_w = 1'b0;
        meta_tag_w   = '0;
        data_wen     = 1'b0;
        cpu_hit      = 1'b0;
`ifdef ICACHE_FLUSH_EN
        flush_done   = 1'b0;
`endif
        case (state)
            IDLE: begin
                meta_idx = req_idx;
                data_idx = req_idx;
                data_off = req_off;
                cpu_hit  = cpu_req & tag_match & ~flush_go;
            end
            REFILL: begin
                data_wen = mem_ack & ~rst;
            end
            COMMIT: begin
                meta_wen     = ~rst;
                meta_valid_w = 1'b1;
                meta_tag_w   = lat_tag;
            end
`ifdef ICACHE_FLUSH_EN
            FLUSH: begin
                meta_idx   = fcnt;
                meta_wen   = ~rst;
                flush_done = ~rst & (fcnt == LAST_IDX);
            end
`endif
            default: ;
        endcase
    end

    assign cpu_stall  = cpu_req & ~cpu_hit;
    assign data_wdata = mem_rdata;
    assign mem_req    = mem_req_r;
    assign mem_addr   = {lat_tag, lat_idx, cnt, 2'b00};

endmodule

// File: tb/tb_icache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_ctrl
// Directed bench for icache_ctrl with default geometry (16 lines, 4 words).
// Stimulus pushes expected data writes, meta writes, memory addresses and
// lookup results into queues; a negedge monitor pops and compares whenever
// the DUT presents the corresponding output. The valid/tag arrays are modelled
// here as async-read memories cleared by rst.
// -----------------------------------------------------------------------------
module tb_icache_ctrl;

    localparam int BI = 4;
    localparam int OB = 2;
    localparam int TB_BITS = 30 - OB - BI;

    logic                clk = 1'b0;
    logic                rst;
    logic                cpu_req;
    logic [31:0]         cpu_addr;
    logic                cpu_hit;
    logic                cpu_stall;
    logic [BI-1:0]       meta_idx;
    logic                meta_valid_r;
    logic [TB_BITS-1:0]  meta_tag_r;
    logic                meta_wen;
    logic                meta_valid_w;
    logic [TB_BITS-1:0]  meta_tag_w;
    logic                data_wen;
    logic [BI-1:0]       data_idx;
    logic [OB-1:0]       data_off;
    logic [31:0]         data_wdata;
    logic                mem_req;
    logic [31:0]         mem_addr;
    logic                mem_ack;
    logic [31:0]         mem_rdata;
`ifdef ICACHE_FLUSH_EN
    logic                flush;
    logic                flush_done;
`endif

    always #5 clk = ~clk;

    icache_ctrl #(.BLKIDX_BIT(BI), .OFF_BIT(OB)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef ICACHE_FLUSH_EN
        .flush        (flush),
        .flush_done   (flush_done),
`endif
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_hit      (cpu_hit),
        .cpu_stall    (cpu_stall),
        .meta_idx     (meta_idx),
        .meta_valid_r (meta_valid_r),
        .meta_tag_r   (meta_tag_r),
        .meta_wen     (meta_wen),
        .meta_valid_w (meta_valid_w),
        .meta_tag_w   (meta_tag_w),
        .data_wen     (data_wen),
        .data_idx     (data_idx),
        .data_off     (data_off),
        .data_wdata   (data_wdata),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    // Valid/tag arrays: async read, cleared by rst
    logic               vmem [16];
    logic [TB_BITS-1:0] tmem [16];

    assign meta_valid_r = vmem[meta_idx];
    assign meta_tag_r   = tmem[meta_idx];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                vmem[i] <= 1'b0;
                tmem[i] <= '0;
            end
        end else if (meta_wen) begin
            vmem[meta_idx] <= meta_valid_w;
            tmem[meta_idx] <= meta_tag_w;
        end
    end

    // Scoreboard
    logic [BI+OB+31:0]   exp_dw [$];   // {idx, off, data}
    logic [BI+TB_BITS:0] exp_mw [$];   // {idx, valid, tag}
    logic [31:0]         exp_ma [$];   // mem_addr at each accepted beat
    logic                exp_hit [$];
    logic                look = 1'b0;
    int                  checks = 0;
    int                  errors = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (data_wen) begin
                if (exp_dw.size() == 0) chk("unexpected data_wen", 64'd1, 64'd0);
                else chk("data write", {data_idx, data_off, data_wdata}, exp_dw.pop_front());
            end
            if (meta_wen) begin
                if (exp_mw.size() == 0) chk("unexpected meta_wen", 64'd1, 64'd0);
                else chk("meta write", {meta_idx, meta_valid_w, meta_tag_w}, exp_mw.pop_front());
            end
            if (mem_req && mem_ack) begin
                if (exp_ma.size() == 0) chk("unexpected beat", 64'd1, 64'd0);
                else chk("mem_addr", mem_addr, exp_ma.pop_front());
            end
            if (look) begin
                logic e;
                e = exp_hit.pop_front();
                chk("cpu_hit", cpu_hit, e);
                chk("cpu_stall", cpu_stall, !e);
            end
`ifdef ICACHE_FLUSH_EN
            if (meta_wen && !meta_valid_w) chk("flush_done", flush_done, meta_idx == 4'hF);
            else if (flush_done) chk("stray flush_done", 64'd1, 64'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup_cycle(input logic [31:0] addr, input logic e);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        exp_hit.push_back(e);
        look = 1'b1;
        tick();
        look = 1'b0;
    endtask

    // Miss on addr, refill with words d0..d0+3 (gaps on odd beats), commit,
    // then retry. With fl_mid a flush is raised during the refill and must
    // run right after the commit.
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] d0, input bit fl_mid);
        logic [BI-1:0]      idx;
        logic [TB_BITS-1:0] tg;
        idx = addr[7:4];
        tg  = addr[31:8];
        lookup_cycle(addr, 1'b0);
        chk("mem_req at refill", mem_req, 64'd1);
        chk("mem_addr at refill", mem_addr, {addr[31:4], 4'h0});
        for (int b = 0; b < 4; b++) begin
            exp_ma.push_back({addr[31:4], 2'(b), 2'b00});
            exp_dw.push_back({idx, 2'(b), d0 + 32'(b)});
        end
        exp_mw.push_back({idx, 1'b1, tg});
        for (int b = 0; b < 4; b++) begin
            repeat (b % 2) tick();
`ifdef ICACHE_FLUSH_EN
            if (fl_mid && b == 0) flush = 1'b1;
`endif
            mem_ack   = 1'b1;
            mem_rdata = d0 + 32'(b);
            tick();
            mem_ack   = 1'b0;
`ifdef ICACHE_FLUSH_EN
            flush     = 1'b0;
`endif
        end
        chk("mem_req in commit", mem_req, 64'd0);
        lookup_cycle(addr, 1'b0);          // COMMIT cycle: no hit
        if (!fl_mid) begin
            lookup_cycle(addr, 1'b1);      // retried lookup hits
        end else begin
            for (int i = 0; i < 16; i++) exp_mw.push_back({4'(i), 1'b0, {TB_BITS{1'b0}}});
            lookup_cycle(addr, 1'b0);      // flush pending takes priority
            cpu_req = 1'b0;
            repeat (16) tick();
        end
        cpu_req = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
`ifdef ICACHE_FLUSH_EN
        flush     = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        chk("reset mem_req", mem_req, 64'd0);
        chk("reset mem_addr", mem_addr, 64'd0);
        chk("reset meta_wen", meta_wen, 64'd0);
        chk("reset data_wen", data_wen, 64'd0);
        chk("reset cpu_stall", cpu_stall, 64'd0);

        // Cold miss, fill A0..A3, then hits on the same line
        do_miss(32'h0000_1234, 32'h0000_00A0, 1'b0);
        lookup_cycle(32'h0000_1238, 1'b1);
        lookup_cycle(32'h0000_123C, 1'b1);
        cpu_req = 1'b0;

        // Conflict on index 3, then the evicted line misses again
        do_miss(32'h0000_2234, 32'h0000_00B0, 1'b0);
        do_miss(32'h0000_1234, 32'h0000_00C0, 1'b0);

        // Reset after two beats of a refill on index 7
        lookup_cycle(32'h0000_5670, 1'b0);
        for (int b = 0; b < 2; b++) begin
            exp_ma.push_back({28'h0000_567, 2'(b), 2'b00});
            exp_dw.push_back({4'h7, 2'(b), 32'h0000_0D00 + 32'(b)});
        end
        for (int b = 0; b < 2; b++) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h0000_0D00 + 32'(b);
            tick();
            mem_ack   = 1'b0;
        end
        rst     = 1'b1;
        cpu_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("mem_req after rst", mem_req, 64'd0);
        chk("meta_wen after rst", meta_wen, 64'd0);
        chk("mem_addr after rst", mem_addr, 64'd0);
        do_miss(32'h0000_1234, 32'h0000_0010, 1'b0);
        do_miss(32'h0000_5670, 32'h0000_0020, 1'b0);

`ifdef ICACHE_FLUSH_EN
        // Flush with a pending fetch in IDLE: flush wins
        for (int i = 0; i < 16; i++) exp_mw.push_back({4'(i), 1'b0, {TB_BITS{1'b0}}});
        flush = 1'b1;
        lookup_cycle(32'h0000_1234, 1'b0);
        flush   = 1'b0;
        cpu_req = 1'b0;
        repeat (16) tick();
        do_miss(32'h0000_1234, 32'h0000_00E0, 1'b1);
        do_miss(32'h0000_5670, 32'h0000_00F0, 1'b0);
`endif

        repeat (2) tick();
        chk("data writes left", 64'(exp_dw.size()), 64'd0);
        chk("meta writes left", 64'(exp_mw.size()), 64'd0);
        chk("beats left", 64'(exp_ma.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
